// File: rtl/ihs_isa_pkg.sv
// Shared ISA definitions: opcode constants, cycle-counter encodings and
// sequencer state type, used by instr_sequencer and the control unit.
// No ports; import with `import ihs_isa_pkg::*;`.
package ihs_isa_pkg;

  // Opcode field is in_instr[15:13]; 011 and 110 are unassigned.
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] NAN = 3'b010;
  localparam logic [2:0] OUT = 3'b100;
  localparam logic [2:0] LDI = 3'b101;
  localparam logic [2:0] REP = 3'b111;

  // Per-instruction cycle counter seen by the control unit.
  typedef enum logic [1:0] {
    CYC_00 = 2'b00,
    CYC_01 = 2'b01,
    CYC_10 = 2'b10,
    CYC_11 = 2'b11
  } cycle_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ADD) || (op == SUB) || (op == NAN) ||
           (op == OUT) || (op == LDI) || (op == REP);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: DEPTH-entry circular buffer, head visible the cycle
// after a push (no bypass). Ports: clock/resetn, push+push_data, pop, flush,
// head (entry at read pointer), count (0..DEPTH), full.
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [4:0]       count,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full = (count == 5'(DEPTH));
  assign head = mem[rd_ptr];

  // Flush wins over both a same-cycle push and pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count != 5'd0) && !flush;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits and DEPTH is a power of two, so the
  // increment wraps modulo DEPTH on its own.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: queues host instructions and issues them one at a
// time to the control unit, stepping current_state 00..11 and waiting at 11
// for clear_counter (or aborting after TIMEOUT cycles). Ports: host side
// in_valid/in_instr/in_ready; controls run/flush; control-unit side
// instruction/current_state/clear_counter; status busy/fifo_count and the
// one-cycle pulses instr_done/illegal_op/timeout.
module instr_sequencer
  import ihs_isa_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        run,
  input  logic        flush,
  output logic [15:0] instruction,
  output logic [1:0]  current_state,
  input  logic        clear_counter,
  output logic        busy,
  output logic [4:0]  fifo_count,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t  state, state_nxt;
  cycle_t      cyc, cyc_nxt;
  logic [15:0] instr_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic        done_nxt, ill_nxt, to_pulse_nxt;
  logic        pop;
  logic        full;
  logic [15:0] head;
  logic        can_pop;
  logic        head_legal;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (in_valid && in_ready),
    .push_data (in_instr),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (full)
  );

  assign in_ready      = !full;
  assign busy          = (state == ISSUE);
  assign current_state = cyc;
  assign can_pop       = run && !flush && (fifo_count != 5'd0);
  assign head_legal    = is_legal_op(head[15:13]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cyc         <= CYC_00;
      instruction <= 16'h0000;
      to_cnt      <= '0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cyc         <= cyc_nxt;
      instruction <= instr_nxt;
      to_cnt      <= to_nxt;
      instr_done  <= done_nxt;
      illegal_op  <= ill_nxt;
      timeout     <= to_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc;
    instr_nxt    = instruction;
    to_nxt       = '0;
    pop          = 1'b0;
    done_nxt     = 1'b0;
    ill_nxt      = 1'b0;
    to_pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        cyc_nxt = CYC_00;
        if (can_pop) begin
          pop = 1'b1;
          if (head_legal) begin
            instr_nxt = head;
            state_nxt = ISSUE;
          end else begin
            ill_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cyc != CYC_11) begin
          cyc_nxt = cycle_t'(cyc + 2'd1);
        end else if (clear_counter) begin
          done_nxt = 1'b1;
          cyc_nxt  = CYC_00;
          // Back-to-back issue only for a legal head; an illegal head is
          // left queued and dropped from IDLE on the following edge.
          if (can_pop && head_legal) begin
            pop       = 1'b1;
            instr_nxt = head;
          end else begin
            state_nxt = IDLE;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          to_pulse_nxt = 1'b1;
          state_nxt    = IDLE;
          cyc_nxt      = CYC_00;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
